// File: rtl/serial_frame_tx.sv
// Asynchronous-serial frame transmitter: start bit, LSB-first data, optional even parity
// (enabled by defining SERIAL_FRAME_TX_PARITY_EN), then one or two stop bits.
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             txd,
  output logic             busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity_q;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [CNT_W-1:0]  bit_q;
  logic [WIDTH-1:0]  shift_q;
  logic [WIDTH-1:0]  shift_d;
  logic              txd_q;
  logic              busy_q;
  logic              rdy_q;
  logic              baud_done;

  always_comb begin
    shift_d   = shift_q >> 1;
    baud_done = (baud_q == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready comes up one edge after reset release, then gates acceptance
          rdy_q <= 1'b1;
          if (in_valid && rdy_q) begin
            shift_q  <= in_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q <= ^in_data;
`endif
            state_q  <= START;
            baud_q   <= BAUD_LAST;
            bit_q    <= '0;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
            rdy_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state_q <= DATA;
            baud_q  <= BAUD_LAST;
            txd_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= BAUD_LAST;
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
              state_q <= PARITY;
              txd_q   <= parity_q;
`else
              state_q <= STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + CNT_W'(1);
              shift_q <= shift_d;
              txd_q   <= shift_d[0];
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            state_q <= STOP;
            baud_q  <= BAUD_LAST;
            txd_q   <= 1'b1;
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            if (bit_q == STOP_LAST) begin
              state_q <= IDLE;
              bit_q   <= '0;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
            end else begin
              bit_q  <= bit_q + CNT_W'(1);
              baud_q <= BAUD_LAST;
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign in_ready = rdy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: WIDTH=8, 4 clocks per bit; parity/2-stop variant
// selected by SERIAL_FRAME_TX_PARITY_EN.
module tb_serial_frame_tx;

  localparam int C = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int S = 2;
  localparam int N = 12;
  localparam int PERIOD = 49;
`else
  localparam int S = 1;
  localparam int N = 10;
  localparam int PERIOD = 41;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       txd;
  logic       busy;

  int cyc = 0;
  int n_tot = 0;
  int n_bad = 0;

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .STOP_BITS(S)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .txd      (txd),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    logic [0:15] seq;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Called at a negedge; waits for in_ready, presents d, returns at the negedge of the first start cycle.
  task automatic accept(input logic [7:0] d);
    int k = 0;
    while (in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts at the negedge of the first start cycle; ends at the negedge of the idle cycle after the frame.
  task automatic run_frame(input string tag, input logic [0:15] seq, input bit noisy,
                           input bit keep_valid, output int t_start);
    t_start = cyc;
    for (int j = 0; j < C * N; j++) begin
      if (j > 0) @(negedge clk);
      if (noisy) begin
        in_data  = j[0] ? 8'h55 : 8'hAA;
        in_valid = j[1];
      end else if (!keep_valid) begin
        in_valid = 1'b0;
      end
      chk({tag, "_txd"}, {31'd0, txd}, {31'd0, seq[j / C]});
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_idle_txd"}, {31'd0, txd}, 32'd1);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = keep_valid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int t2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    vecs[0] = '{8'hA5, 16'b010100101011_0000};
    vecs[1] = '{8'h00, 16'b000000000011_0000};
    vecs[2] = '{8'hFF, 16'b011111111011_0000};
    vecs[3] = '{8'h3C, 16'b000111100011_0000};
    vecs[4] = '{8'h07, 16'b011100000111_0000};
`else
    vecs[0] = '{8'hA5, 16'b0101001011_000000};
    vecs[1] = '{8'h00, 16'b0000000001_000000};
    vecs[2] = '{8'hFF, 16'b0111111111_000000};
    vecs[3] = '{8'h3C, 16'b0001111001_000000};
    vecs[4] = '{8'h01, 16'b0100000001_000000};
`endif

    // Reset held with in_valid asserted
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", {31'd0, in_ready}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_txd", {31'd0, txd}, 32'd1);

    // Table of single frames
    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].data);
      run_frame($sformatf("vec%0d", v), vecs[v].seq, 1'b0, 1'b0, t1);
      @(negedge clk);
    end

    // Back-to-back 0x00 then 0xFF with in_valid held
    accept(8'h00);
    in_data = 8'hFF;
    run_frame("b2b0", vecs[1].seq, 1'b0, 1'b1, t1);
    @(posedge clk);
    @(negedge clk);
    run_frame("b2b1", vecs[2].seq, 1'b0, 1'b0, t2);
    chk("b2b_period", t2 - t1, PERIOD);
    @(negedge clk);

    // Inputs toggled while busy must not disturb a 0x3C frame
    accept(8'h3C);
    run_frame("noisy", vecs[3].seq, 1'b1, 1'b0, t1);
    @(negedge clk);
    chk("noisy_after_busy", {31'd0, busy}, 32'd0);

    // Reset during data bit 3 of 0xC3 (bit 3 = 0), then a clean 0x3C frame
    accept(8'hC3);
    in_valid = 1'b0;
    repeat (C * 4 + 1) @(negedge clk);
    chk("mid_txd", {31'd0, txd}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_txd", {31'd0, txd}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arel_rdy", {31'd0, in_ready}, 32'd1);
    accept(8'h3C);
    run_frame("post_rst", vecs[3].seq, 1'b0, 1'b0, t1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
